// File: rtl/scan_scheduler.sv
// scan_scheduler: round-robin owner of a shared transfer station for two scanners.
// Each grant runs a fixed sequence: GRANT -> XFER (until done) -> FLUSH -> REARM -> IDLE.
// Optional feature macro: SCAN_SCHED_TIMEOUT_EN adds a per-grant watchdog (XFER_TIMEOUT
// cycles), a sticky timeout_err, and suppresses the completed-transfer count on timeout.
module scan_scheduler #(
  parameter int XFER_TIMEOUT = 4096,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             station_ready,
  input  logic [1:0]       req,
  input  logic [1:0]       done,
  output logic [1:0]       permit,
  output logic [1:0]       flush,
  output logic [1:0]       start,
  output logic [1:0]       standby,
  output logic             busy,
  output logic             owner,
  output logic [CNT_W-1:0] xfer_count,
  output logic             timeout_err
);

  typedef enum logic [2:0] {IDLE, GRANT, XFER, FLUSH, REARM} state_t;

  state_t state;
  logic   timed_out;   // current grant ended through the watchdog, not through done
  logic   owner_done;  // only the owner's done matters; the other scanner's is ignored
  logic   pick;        // round-robin winner for the current req pattern
  logic   launch;
  logic   to_hit;      // watchdog expires this cycle

  assign owner_done = done[owner];
  assign launch     = enable & station_ready & (|req);
  // single requester wins outright; contention goes to the scanner that did not own last
  assign pick       = (req == 2'b01) ? 1'b0 : (req == 2'b10) ? 1'b1 : ~owner;

  // standby only makes sense while parked; held low during reset
  assign standby = (rst && state == IDLE && !enable) ? 2'b11 : 2'b00;

  // main sequencer: state plus registered permit/flush/start/busy/owner/count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      permit     <= 2'b00;
      flush      <= 2'b00;
      start      <= 2'b00;
      busy       <= 1'b0;
      owner      <= 1'b1;
      xfer_count <= '0;
      timed_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state  <= GRANT;
            owner  <= pick;
            permit <= pick ? 2'b10 : 2'b01;
            busy   <= 1'b1;
          end
        end
        GRANT, XFER: begin
          if (owner_done || to_hit) begin
            state     <= FLUSH;
            permit    <= 2'b00;
            flush     <= owner ? 2'b10 : 2'b01;
            timed_out <= !owner_done;
          end else begin
            state <= XFER;
          end
        end
        FLUSH: begin
          flush <= 2'b00;
          start <= owner ? 2'b10 : 2'b01;
          state <= REARM;
        end
        REARM: begin
          start     <= 2'b00;
          busy      <= 1'b0;
          state     <= IDLE;
          timed_out <= 1'b0;
          if (!timed_out) xfer_count <= xfer_count + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCAN_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(XFER_TIMEOUT + 1);

  logic [TW-1:0] tcnt;
  logic          in_grant;

  assign in_grant = (state == GRANT) || (state == XFER);
  // tcnt counts grant cycles already spent; expiry lands on the XFER_TIMEOUT-th one
  assign to_hit   = in_grant && (tcnt == TW'(XFER_TIMEOUT - 1));

  // grant-cycle counter, cleared whenever the grant ends or is not held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   tcnt <= '0;
    else if (in_grant && !owner_done && !to_hit) tcnt <= tcnt + TW'(1);
    else                                        tcnt <= '0;
  end

  // sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      timeout_err <= 1'b0;
    else if (to_hit && !owner_done) timeout_err <= 1'b1;
  end
`else
  // no watchdog: a grant is held until done; constant 0 for any legal XFER_TIMEOUT
  assign to_hit      = (XFER_TIMEOUT < 0);
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_scan_scheduler.sv
// Bench for scan_scheduler: directed scenarios plus randomized transfers, checked
// transaction by transaction against a round-robin / counter model kept here.
module tb_scan_scheduler;
  localparam int CNT_W = 8;
  localparam int TMO   = 16;

  logic             clk = 1'b0, rst = 1'b0, enable = 1'b0, station_ready = 1'b0;
  logic [1:0]       req = 2'b00, done = 2'b00;
  logic [1:0]       permit, flush, start, standby;
  logic             busy, owner, timeout_err;
  logic [CNT_W-1:0] xfer_count;

  scan_scheduler #(.XFER_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .station_ready(station_ready),
    .req(req), .done(done), .permit(permit), .flush(flush), .start(start),
    .standby(standby), .busy(busy), .owner(owner), .xfer_count(xfer_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int npass = 0, nfail = 0, ntot = 0;
  bit m_owner = 1'b1;  // model: last granted scanner
  int m_cnt   = 0;     // model: completed transfers (unwrapped)

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] oh(input bit i);
    return i ? 2'b10 : 2'b01;
  endfunction

  function automatic bit rr(input logic [1:0] p);
    if (p == 2'b01) return 1'b0;
    if (p == 2'b10) return 1'b1;
    return !m_owner;
  endfunction

  // one full transfer from IDLE: grant, hold, done, flush, start, back to IDLE
  task automatic xfer(input logic [1:0] pat, input int hold, input bit noise, input bit drop_en);
    bit w;
    w = rr(pat);
    enable = 1'b1; station_ready = 1'b1; req = pat; done = 2'b00;
    tick();
    check("grant_permit", 32'(permit), 32'(oh(w)));
    check("grant_owner", 32'(owner), 32'(w));
    check("grant_busy", 32'(busy), 32'd1);
    m_owner = w;
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        req           = 2'($urandom);
        station_ready = 1'($urandom);
        done          = ($urandom_range(0, 1) == 1) ? oh(!w) : 2'b00;
      end
      if (drop_en && i == 0) enable = 1'b0;
      tick();
      check("hold_permit", 32'(permit), 32'(oh(w)));
      check("hold_standby", 32'(standby), 32'd0);
    end
    done = oh(w);
    tick();
    check("flush_pulse", 32'(flush), 32'(oh(w)));
    check("flush_permit", 32'(permit), 32'd0);
    done = 2'b00; req = 2'b00;
    tick();
    check("start_pulse", 32'(start), 32'(oh(w)));
    check("start_flush", 32'(flush), 32'd0);
    tick();
    m_cnt++;
    check("idle_start", 32'(start), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_count", 32'(xfer_count), 32'(m_cnt % 256));
    check("idle_standby", 32'(standby), enable ? 32'd0 : 32'd3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit w;
    // reset state (enable low, standby must still be 0 under reset)
    tick(); tick();
    check("rst_permit", 32'(permit), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_standby", 32'(standby), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd1);
    check("rst_count", 32'(xfer_count), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    rst = 1'b1;
    tick();

    // contested requests alternate, scanner 0 first
    xfer(2'b11, 2, 1'b0, 1'b0);
    xfer(2'b11, 2, 1'b0, 1'b0);
    xfer(2'b11, 0, 1'b0, 1'b0);  // done during GRANT

    // other scanner's done and req churn ignored while holding
    xfer(2'b01, 5, 1'b1, 1'b0);

    // enable low in IDLE: standby, no grant
    enable = 1'b0; station_ready = 1'b1; req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dis_standby", 32'(standby), 32'd3);
      check("dis_permit", 32'(permit), 32'd0);
      check("dis_busy", 32'(busy), 32'd0);
    end
    // enable dropped mid-transfer: completes, then parks in standby
    xfer(2'b01, 3, 1'b0, 1'b1);
    req = 2'b11;
    tick(); tick();
    check("dis_nogrant", 32'(busy), 32'd0);
    check("dis_standby2", 32'(standby), 32'd3);

    // station not ready: wait
    enable = 1'b1; station_ready = 1'b0; req = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nrdy_permit", 32'(permit), 32'd0);
      check("nrdy_busy", 32'(busy), 32'd0);
    end
    req = 2'b00;

`ifdef SCAN_SCHED_TIMEOUT_EN
    // watchdog: TMO grant cycles without done
    w = rr(2'b10);
    station_ready = 1'b1; req = 2'b10;
    tick();
    check("tmo_grant", 32'(permit), 32'(oh(w)));
    m_owner = w; req = 2'b00;
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
      check("tmo_hold", 32'(permit), 32'(oh(w)));
      check("tmo_err0", 32'(timeout_err), 32'd0);
    end
    tick();
    check("tmo_flush", 32'(flush), 32'(oh(w)));
    check("tmo_err1", 32'(timeout_err), 32'd1);
    tick();
    check("tmo_start", 32'(start), 32'(oh(w)));
    tick();
    check("tmo_count", 32'(xfer_count), 32'(m_cnt % 256));
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_sticky", 32'(timeout_err), 32'd1);
`else
    // no watchdog: grant held well past XFER_TIMEOUT
    w = 1'b0;
    xfer(2'b10, 3 * TMO, 1'b0, 1'b0);
    check("notmo_err", 32'(timeout_err), 32'd0);
`endif

    // reset mid-XFER drops permit immediately
    w = rr(2'b11);
    enable = 1'b1; station_ready = 1'b1; req = 2'b11;
    tick();
    check("mid_grant", 32'(permit), 32'(oh(w)));
    tick();
    rst = 1'b0;
    #1;
    check("mid_permit", 32'(permit), 32'd0);
    check("mid_owner", 32'(owner), 32'd1);
    check("mid_count", 32'(xfer_count), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_flush", 32'(flush), 32'd0);
    check("mid_err", 32'(timeout_err), 32'd0);
    req = 2'b00;
    tick();
    check("mid_start", 32'(start), 32'd0);
    rst = 1'b1;
    m_owner = 1'b1; m_cnt = 0;

    // randomized transfers, 256 of them wrap the counter back to 0
    for (int n = 0; n < 256; n++)
      xfer(2'($urandom_range(1, 3)), $urandom_range(0, 3), 1'b1, 1'b0);
    check("wrap_count", 32'(xfer_count), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
